// File: rtl/cache_flush_engine_pkg.sv
// Shared types for the L1 write-back flush engine.
package cache_flush_engine_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCheck,
    StWrite,
    StClear,
    StDone
  } flush_state_e;

  // Byte-offset bits of one cache line within the external address.
  function automatic int unsigned off_bits(int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/cache_flush_engine.sv
// Walks every cache line and writes valid+dirty lines to external memory over cs/we/ack,
// then cleans (optionally invalidates) them.
module cache_flush_engine
  import cache_flush_engine_pkg::*;
#(
  parameter int unsigned  DATA_W     = 256,
  parameter int unsigned  NUM_LINES  = 32,
  parameter int unsigned  TAG_W      = 22,
  parameter int unsigned  ADDR_W     = 32,
  parameter bit           INVALIDATE = 1'b0,
  localparam int unsigned IDX_W      = $clog2(NUM_LINES)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [IDX_W:0]    o_wb_count,
  output logic [IDX_W-1:0]  o_line_idx,
  output logic              o_line_re,
  input  logic [TAG_W-1:0]  i_line_tag,
  input  logic [DATA_W-1:0] i_line_data,
  input  logic              i_line_valid,
  input  logic              i_line_dirty,
  output logic              o_line_clr,
  output logic              o_line_inv,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  input  logic              i_mem_ack
);

  localparam int unsigned OFF_W = off_bits(DATA_W);

  flush_state_e      r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W:0]    r_wb_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic              w_wb_needed;

  assign w_last      = (r_idx == IDX_W'(NUM_LINES - 1));
  assign w_wb_needed = i_line_valid & i_line_dirty;

  // Address bits above tag/index/offset stay zero.
  always_comb begin
    w_addr = '0;
    w_addr[OFF_W +: IDX_W]         = r_idx;
    w_addr[OFF_W + IDX_W +: TAG_W] = i_line_tag;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (i_flush_req) w_state_nxt = StRead;
      StRead:  w_state_nxt = StCheck;
      StCheck: begin
        if (w_wb_needed)  w_state_nxt = StWrite;
        else if (w_last)  w_state_nxt = StDone;
        else              w_state_nxt = StRead;
      end
      StWrite: if (i_mem_ack) w_state_nxt = StClear;
      StClear: w_state_nxt = w_last ? StDone : StRead;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_wb_count <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_flush_req) begin
            r_idx      <= '0;
            r_wb_count <= '0;
          end
        end
        StCheck: begin
          if (w_wb_needed) begin
            r_addr <= w_addr;
            r_data <= i_line_data;
          end else if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StClear: begin
          r_wb_count <= r_wb_count + 1'b1;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state == StRead) || (r_state == StCheck) ||
                      (r_state == StWrite) || (r_state == StClear);
  assign o_done     = (r_state == StDone);
  assign o_line_re  = (r_state == StRead);
  assign o_line_clr = (r_state == StClear);
  assign o_line_inv = (r_state == StClear) && INVALIDATE;
  assign o_mem_cs   = (r_state == StWrite);
  assign o_mem_we   = (r_state == StWrite);
  assign o_line_idx = r_idx;
  assign o_wb_count = r_wb_count;
  assign o_mem_addr = r_addr;
  assign o_mem_data = r_data;

endmodule

// File: tb/tb_cache_flush_engine.sv
// Bench for cache_flush_engine: one default instance (A) and one 64-line/128-bit invalidating
// instance (B) sharing a line-storage model and a DRAM responder.
module tb_cache_flush_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic req;
  logic sel;
  logic ack;
  int   mem_delay = 1;

  always #5 clk = ~clk;

  logic         busy_a, done_a, re_a, clr_a, inv_a, cs_a, we_a;
  logic [5:0]   wb_a;
  logic [4:0]   idx_a;
  logic [31:0]  addr_a;
  logic [255:0] mdata_a;
  logic         busy_b, done_b, re_b, clr_b, inv_b, cs_b, we_b;
  logic [6:0]   wb_b;
  logic [5:0]   idx_b;
  logic [31:0]  addr_b;
  logic [127:0] mdata_b;

  logic [21:0]  rd_tag;
  logic [255:0] rd_data;
  logic         rd_valid, rd_dirty;

  cache_flush_engine u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush_req(req & ~sel), .o_busy(busy_a), .o_done(done_a),
    .o_wb_count(wb_a), .o_line_idx(idx_a), .o_line_re(re_a), .i_line_tag(rd_tag),
    .i_line_data(rd_data), .i_line_valid(rd_valid), .i_line_dirty(rd_dirty),
    .o_line_clr(clr_a), .o_line_inv(inv_a), .o_mem_addr(addr_a), .o_mem_data(mdata_a),
    .o_mem_cs(cs_a), .o_mem_we(we_a), .i_mem_ack(ack)
  );

  cache_flush_engine #(.DATA_W(128), .NUM_LINES(64), .INVALIDATE(1'b1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush_req(req & sel), .o_busy(busy_b), .o_done(done_b),
    .o_wb_count(wb_b), .o_line_idx(idx_b), .o_line_re(re_b), .i_line_tag(rd_tag),
    .i_line_data(rd_data[127:0]), .i_line_valid(rd_valid), .i_line_dirty(rd_dirty),
    .o_line_clr(clr_b), .o_line_inv(inv_b), .o_mem_addr(addr_b), .o_mem_data(mdata_b),
    .o_mem_cs(cs_b), .o_mem_we(we_b), .i_mem_ack(ack)
  );

  logic         busy, done, re, clr, inv, cs, we;
  logic [6:0]   wb;
  logic [5:0]   idx;
  logic [31:0]  addr;
  logic [255:0] mdata;
  assign busy  = sel ? busy_b : busy_a;
  assign done  = sel ? done_b : done_a;
  assign re    = sel ? re_b : re_a;
  assign clr   = sel ? clr_b : clr_a;
  assign inv   = sel ? inv_b : inv_a;
  assign cs    = sel ? cs_b : cs_a;
  assign we    = sel ? we_b : we_a;
  assign wb    = sel ? wb_b : {1'b0, wb_a};
  assign idx   = sel ? idx_b : {1'b0, idx_a};
  assign addr  = sel ? addr_b : addr_a;
  assign mdata = sel ? {128'b0, mdata_b} : mdata_a;

  // Line storage contents (written only by the stimulus process).
  logic         v_mem[64];
  logic         d_mem[64];
  logic [21:0]  t_mem[64];
  logic [255:0] x_mem[64];

  logic [31:0]  obs_addr[$];
  logic [255:0] obs_data[$];
  int           obs_clr[$];
  bit           obs_inv[$];
  int           obs_reads[$];
  int           done_cnt = 0;
  int           unstable = 0;
  logic         prev_cs = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [255:0] prev_data = '0;
  int           wcnt;

  // DRAM: ack rises after mem_delay cycles of cs, held one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (cs && !ack) begin
      if (wcnt + 1 >= mem_delay) begin
        ack  <= 1'b1;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (re) begin
      rd_tag   <= t_mem[idx];
      rd_data  <= x_mem[idx];
      rd_valid <= v_mem[idx];
      rd_dirty <= d_mem[idx];
      obs_reads.push_back(int'(idx));
    end
    if (cs && ack) begin
      obs_addr.push_back(addr);
      obs_data.push_back(mdata);
    end
    if (clr) begin
      obs_clr.push_back(int'(idx));
      obs_inv.push_back(inv);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (cs && (!we || (prev_cs && (addr !== prev_addr || mdata !== prev_data))))
      unstable <= unstable + 1;
    prev_cs   <= cs;
    prev_addr <= addr;
    prev_data <= mdata;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 64; i++) begin
      v_mem[i] = 1'b0;
      d_mem[i] = 1'b0;
      t_mem[i] = '0;
      x_mem[i] = '0;
    end
  endtask

  task automatic rand_fill();
    for (int i = 0; i < 64; i++) begin
      v_mem[i] = 1'($urandom_range(0, 1));
      d_mem[i] = 1'($urandom_range(0, 3) == 0);
      t_mem[i] = 22'($urandom);
      x_mem[i] = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Reference: every valid+dirty line, in index order, is written once and cleared.
  task automatic run_flush(input int delay, input bit repulse);
    int           nl, offw, idxw, exp_cyc, cyc, rb, ab, cb, db, nw, nc;
    logic [31:0]  ea[$];
    logic [255:0] ed[$];
    int           ec[$];
    logic [255:0] mask;
    mem_delay = delay;
    nl   = sel ? 64 : 32;
    offw = sel ? 4 : 5;
    idxw = sel ? 6 : 5;
    mask = sel ? {128'b0, {128{1'b1}}} : {256{1'b1}};
    exp_cyc = 1;
    for (int i = 0; i < nl; i++) begin
      if (v_mem[i] && d_mem[i]) begin
        ea.push_back((32'(t_mem[i]) << (idxw + offw)) | (32'(i) << offw));
        ed.push_back(x_mem[i] & mask);
        ec.push_back(i);
        exp_cyc += 3 + delay + 1;
      end else begin
        exp_cyc += 2;
      end
    end
    rb = obs_reads.size();
    ab = obs_addr.size();
    cb = obs_clr.size();
    db = done_cnt;
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    cyc = 1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (repulse && cyc == 5) req = 1'b1;
      if (cyc == 6) req = 1'b0;
    end
    chk("done_latency", 256'(cyc), 256'(exp_cyc));
    chk("wb_count", 256'(wb), 256'(ea.size()));
    repeat (3) @(negedge clk);
    chk("done_pulses", 256'(done_cnt - db), 256'd1);
    chk("busy_after", 256'(busy), 256'd0);
    nw = obs_addr.size() - ab;
    chk("n_writes", 256'(nw), 256'(ea.size()));
    for (int k = 0; k < nw && k < ea.size(); k++) begin
      chk("wr_addr", 256'(obs_addr[ab + k]), 256'(ea[k]));
      chk("wr_data", obs_data[ab + k], ed[k]);
    end
    nc = obs_clr.size() - cb;
    chk("n_clears", 256'(nc), 256'(ec.size()));
    for (int k = 0; k < nc && k < ec.size(); k++) begin
      chk("clr_idx", 256'(obs_clr[cb + k]), 256'(ec[k]));
      chk("clr_inv", 256'(obs_inv[cb + k]), 256'(sel));
      d_mem[obs_clr[cb + k]] = 1'b0;
      if (obs_inv[cb + k]) v_mem[obs_clr[cb + k]] = 1'b0;
    end
    chk("n_reads", 256'(obs_reads.size() - rb), 256'(nl));
    if (obs_reads.size() > rb) begin
      chk("first_read", 256'(obs_reads[rb]), 256'd0);
      chk("last_read", 256'(obs_reads[obs_reads.size() - 1]), 256'(nl - 1));
    end
    chk("stable_write", 256'(unstable), 256'd0);
  endtask

  initial begin
    int cb, w;
    rst_n = 1'b0;
    req   = 1'b0;
    sel   = 1'b0;
    clear_all();
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_wb", 256'(wb), 256'd0);
    chk("rst_cs", 256'(cs), 256'd0);
    chk("rst_we", 256'(we), 256'd0);
    chk("rst_re", 256'(re), 256'd0);
    chk("rst_clr", 256'(clr), 256'd0);
    chk("rst_idx", 256'(idx), 256'd0);
    chk("rst_addr", 256'(addr), 256'd0);
    chk("rst_data", mdata, 256'd0);
    rst_n = 1'b1;

    // All clean.
    run_flush(1, 1'b0);

    // Single dirty line, slow DRAM.
    v_mem[3] = 1'b1; d_mem[3] = 1'b1; t_mem[3] = 22'h15; x_mem[3] = {32{8'hA5}};
    run_flush(10, 1'b0);
    if (obs_addr.size() > 0) chk("t2_addr", 256'(obs_addr[obs_addr.size() - 1]), 256'h5460);

    // Valid-clean and dirty-invalid lines are skipped.
    clear_all();
    v_mem[5] = 1'b1; d_mem[6] = 1'b1;
    run_flush(1, 1'b0);

    // Extra flush_req while busy is ignored.
    v_mem[2] = 1'b1; d_mem[2] = 1'b1; t_mem[2] = 22'h3ABCD; x_mem[2] = {8{32'hDEADBEEF}};
    run_flush(2, 1'b1);

    // Reset in the middle of a write.
    v_mem[3] = 1'b1; d_mem[3] = 1'b1; t_mem[3] = 22'h2A; x_mem[3] = {16{16'h1234}};
    mem_delay = 20;
    cb = obs_clr.size();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    w = 0;
    while (!cs && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_cs_seen", 256'(cs), 256'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs", 256'(cs), 256'd0);
    chk("rst_mid_we", 256'(we), 256'd0);
    chk("rst_mid_busy", 256'(busy), 256'd0);
    chk("rst_mid_noclr", 256'(obs_clr.size()), 256'(cb));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_flush(3, 1'b0);

    // Random contents on the default instance.
    for (int r = 0; r < 3; r++) begin
      rand_fill();
      run_flush($urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    // 64-line, 128-bit invalidating instance: first and last lines dirty.
    sel = 1'b1;
    clear_all();
    v_mem[0]  = 1'b1; d_mem[0]  = 1'b1; t_mem[0]  = 22'h1; x_mem[0]  = {8{32'h0BADF00D}};
    v_mem[63] = 1'b1; d_mem[63] = 1'b1; t_mem[63] = 22'h3FFFFF; x_mem[63] = {8{32'hCAFEF00D}};
    run_flush(4, 1'b0);
    for (int r = 0; r < 3; r++) begin
      rand_fill();
      run_flush($urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
